sme_frame_loader: RTL and testbench

Upstream feeder for the string-matching engine. Accepts a host byte stream with a valid/ready handshake, assembles each record (one string or one pattern) into a local buffer, then replays it to the matcher as a contiguous `isstring`/`ispattern` burst on `chardata`. After each pattern burst it holds off further traffic until the matcher reports `valid`, or until a watchdog expires.

---
 rtl/sme_frame_loader.sv | 144 ++++++++++++++
 tb/tb_sme_frame_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_frame_loader.sv
// Host byte stream to string-matcher feeder: buffers one record, then replays it as a gap-free burst.
// Latency: char 0 appears the cycle after the last byte is accepted; input stalls during bursts and while awaiting a result.
module sme_frame_loader #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_is_pat,
   input  logic       in_last,
   input  logic       sme_valid,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   output logic       busy,
   output logic       rec_err,
   output logic       timeout_err
);

   typedef enum logic [2:0] {IDLE, COLLECT, EMIT_STR, EMIT_PAT, WAIT_RES} state_t;

   state_t      state_q;
   logic [7:0]  mem_q [STR_MAX];
   logic [5:0]  len_q;
   logic [4:0]  idx_q;
   logic [6:0]  cnt_q;
   logic        pat_q;
   logic        trunc_q;
   logic        str_loaded_q;
   logic        rec_err_q;
   logic        timeout_err_q;

   logic        accept;
   logic [5:0]  max_len;
   logic        room;
   logic        rec_pat;
   logic        trunc_d;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic        emit_last;
   logic        emitting;

   always_comb begin
      accept    = in_valid && in_ready;
      max_len   = pat_q ? 6'(PAT_MAX) : 6'(STR_MAX);
      room      = len_q < max_len;
      // the record type is only taken from the first byte
      rec_pat   = (state_q == IDLE) ? in_is_pat : pat_q;
      trunc_d   = (state_q == COLLECT) && (trunc_q || !room);
      wr_en     = accept && ((state_q == IDLE) || room);
      wr_addr   = (state_q == IDLE) ? 5'd0 : len_q[4:0];
      emit_last = ({1'b0, idx_q} == (len_q - 6'd1));
      emitting  = (state_q == EMIT_STR) || (state_q == EMIT_PAT);
   end

   assign in_ready    = (state_q == IDLE) || (state_q == COLLECT);
   assign isstring    = (state_q == EMIT_STR);
   assign ispattern   = (state_q == EMIT_PAT);
   assign busy        = (state_q != IDLE);
   assign chardata    = emitting ? mem_q[idx_q] : 8'h00;
   assign rec_err     = rec_err_q;
   assign timeout_err = timeout_err_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         len_q         <= 6'd0;
         idx_q         <= 5'd0;
         cnt_q         <= 7'd0;
         pat_q         <= 1'b0;
         trunc_q       <= 1'b0;
         str_loaded_q  <= 1'b0;
         rec_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         rec_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  pat_q   <= in_is_pat;
                  trunc_q <= 1'b0;
                  len_q   <= 6'd1;
                  state_q <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  if (room) begin
                     len_q <= len_q + 6'd1;
                  end else begin
                     trunc_q <= 1'b1;
                  end
               end
            end
            EMIT_STR, EMIT_PAT: begin
               idx_q <= idx_q + 5'd1;
               if (emit_last) begin
                  cnt_q   <= 7'd0;
                  state_q <= (state_q == EMIT_PAT) ? WAIT_RES : IDLE;
               end
            end
            WAIT_RES: begin
               if (sme_valid) begin
                  state_q <= IDLE;
               end else if (cnt_q == 7'(TIMEOUT - 1)) begin
                  state_q       <= IDLE;
                  timeout_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 7'd1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // End of record: overrides the COLLECT transition chosen above.
         if (accept && in_last) begin
            idx_q <= 5'd0;
            if (!rec_pat) begin
               str_loaded_q <= 1'b1;
               state_q      <= EMIT_STR;
               rec_err_q    <= trunc_d;
            end else if (str_loaded_q) begin
               state_q   <= EMIT_PAT;
               rec_err_q <= trunc_d;
            end else begin
               state_q   <= IDLE;
               rec_err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sme_frame_loader.sv
// Scoreboarded bench for sme_frame_loader: directed records, expected bursts and error pulses queued.
module tb_sme_frame_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_is_pat = 1'b0;
   logic       in_last = 1'b0;
   logic       sme_valid = 1'b0;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       busy;
   logic       rec_err;
   logic       timeout_err;

   sme_frame_loader dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_is_pat   (in_is_pat),
      .in_last     (in_last),
      .sme_valid   (sme_valid),
      .chardata    (chardata),
      .isstring    (isstring),
      .ispattern   (ispattern),
      .busy        (busy),
      .rec_err     (rec_err),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pat;
      logic [7:0] ch;
   } exp_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   exp_t       exp_q[$];
   bit         err_q[$];   // 0 = rec_err expected, 1 = timeout_err expected
   logic [7:0] rec_buf [64];
   exp_t       mon_e;
   bit         mon_k;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe cycle and every error pulse must match the head of its queue.
   always @(negedge clk) begin
      if (isstring || ispattern) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_char: got %0h with no burst expected (t=%0t)", chardata, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("burst_char", 32'({ispattern, isstring, chardata}), 32'({mon_e.pat, ~mon_e.pat, mon_e.ch}));
         end
      end else begin
         chk("idle_chardata", 32'(chardata), 32'h0);
      end
      if (rec_err || timeout_err) begin
         if (err_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_err: got rec_err=%0b timeout_err=%0b (t=%0t)", rec_err, timeout_err, $time);
         end else begin
            mon_k = err_q.pop_front();
            chk("err_pulse", 32'({rec_err, timeout_err}), mon_k ? 32'h1 : 32'h2);
         end
      end
   end

   // Call positioned just after a rising edge; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic pat, input logic last, output int st);
      in_valid  = 1'b1;
      in_data   = d;
      in_is_pat = pat;
      in_last   = last;
      st = 0;
      while (!in_ready && st < 500) begin
         @(posedge clk);
         #1;
         st++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready stayed %0b for %0d cycles", in_ready, st);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_record(input logic pat, input int n, output int stalls);
      int st;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         send_byte(rec_buf[i], pat, (i == n - 1), st);
         stalls += st;
      end
   endtask

   task automatic expect_chars(input logic pat, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{pat: pat, ch: rec_buf[i]});
      end
   endtask

   // Strobe high for exactly n consecutive cycles starting the cycle after the last byte, then low.
   task automatic check_burst(input logic pat, input int n, input string name);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!(pat ? (ispattern && !isstring) : (isstring && !ispattern)) || in_ready || !busy)
            ok = 1'b0;
      end
      @(negedge clk);
      if (isstring || ispattern) ok = 1'b0;
      chk(name, 32'(ok), 32'h1);
   endtask

   initial begin
      int stalls;
      int n;

      // reset state
      #1 reset = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_chardata", 32'(chardata), 32'h0);
      chk("rst_strobes", 32'({isstring, ispattern}), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_errs", 32'({rec_err, timeout_err}), 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      // string "abcdefgh" then pattern "cde"
      for (int i = 0; i < 8; i++) rec_buf[i] = 8'(8'h61 + i);
      expect_chars(1'b0, 8);
      send_record(1'b0, 8, stalls);
      chk("str8_stalls", 32'(stalls), 32'h0);
      check_burst(1'b0, 8, "str8_burst");
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) rec_buf[i] = 8'(8'h63 + i);
      expect_chars(1'b1, 3);
      send_record(1'b1, 3, stalls);
      check_burst(1'b1, 3, "pat3_burst");
      repeat (4) @(negedge clk);
      chk("wait_in_ready", 32'(in_ready), 32'h0);
      chk("wait_busy", 32'(busy), 32'h1);
      @(posedge clk); #1 sme_valid = 1'b1;
      @(posedge clk); #1 sme_valid = 1'b0;
      chk("post_valid_in_ready", 32'(in_ready), 32'h1);

      // pattern before any string is dropped
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      rec_buf[0] = 8'h5E; rec_buf[1] = 8'h61; rec_buf[2] = 8'h62;
      err_q.push_back(1'b0);
      send_record(1'b1, 3, stalls);
      @(negedge clk);
      chk("drop_busy", 32'(busy), 32'h0);
      chk("drop_in_ready", 32'(in_ready), 32'h1);
      repeat (2) @(negedge clk);
      chk("drop_in_ready_later", 32'(in_ready), 32'h1);
      @(posedge clk); #1;

      // 40-byte string truncates to 32
      for (int i = 0; i < 40; i++) rec_buf[i] = 8'(8'h20 + i);
      expect_chars(1'b0, 32);
      err_q.push_back(1'b0);
      send_record(1'b0, 40, stalls);
      chk("str40_stalls", 32'(stalls), 32'h0);
      check_burst(1'b0, 32, "str40_burst");
      @(posedge clk); #1;

      // 11-byte pattern truncates to 8, then sme_valid is withheld
      for (int i = 0; i < 11; i++) rec_buf[i] = 8'(8'h41 + i);
      expect_chars(1'b1, 8);
      err_q.push_back(1'b0);
      err_q.push_back(1'b1);
      send_record(1'b1, 11, stalls);
      check_burst(1'b1, 8, "pat11_burst");
      n = 0;
      while (!timeout_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'd64);
      chk("timeout_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      rec_buf[0] = 8'h7A;
      expect_chars(1'b0, 1);
      send_record(1'b0, 1, stalls);
      chk("after_to_stalls", 32'(stalls), 32'h0);
      check_burst(1'b0, 1, "after_to_burst");
      @(posedge clk); #1;

      // reset in the 5th burst cycle
      for (int i = 0; i < 8; i++) rec_buf[i] = 8'(8'h41 + i);
      expect_chars(1'b0, 4);
      send_record(1'b0, 8, stalls);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("midrst_isstring", 32'(isstring), 32'h0);
      chk("midrst_chardata", 32'(chardata), 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      rec_buf[0] = 8'h78; rec_buf[1] = 8'h79;
      err_q.push_back(1'b0);
      send_record(1'b1, 2, stalls);
      @(negedge clk);
      chk("midrst_drop_busy", 32'(busy), 32'h0);

      repeat (5) @(negedge clk);
      chk("chars_left", 32'(exp_q.size()), 32'h0);
      chk("errs_left", 32'(err_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "global timeout");
   end

endmodule
